// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction loader and the instruction memory.
package inst_loader_pkg;

    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned WORD_BYTES    = 4;
    localparam int unsigned WORD_W        = WORD_BYTES * BYTE_W;
    localparam int unsigned INST_ADDR_LSB = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHK   = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/inst_word_packer.sv
// Assembles big-endian 32-bit words from an accepted byte stream.
module inst_word_packer
    import inst_loader_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_byte_en,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [WORD_W-1:0] o_word_c,
    output logic              o_word_valid_c
);

    localparam int unsigned CNT_W = $clog2(WORD_BYTES);

    logic [CNT_W-1:0]         r_cnt;
    logic [WORD_W-BYTE_W-1:0] r_shift;

    // Earlier bytes shift toward the MSB so the first byte lands in [31:24].
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_clear) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (i_byte_en) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_shift <= {r_shift[WORD_W-2*BYTE_W-1:0], i_byte};
        end
    end

    assign o_word_c       = {r_shift, i_byte};
    assign o_word_valid_c = i_byte_en && (r_cnt == CNT_W'(WORD_BYTES - 1));

endmodule

// File: rtl/inst_loader.sv
// Downloads a length-prefixed byte stream into instruction memory while holding the CPU.
// Optional trailing XOR checksum byte enabled by INST_LOADER_CKSUM_EN.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Clrn,
    input  logic              Start,
    input  logic [BYTE_W-1:0] RxData,
    input  logic              RxValid,
    output logic              RxReady,
    output logic              WrEn,
    output logic [31:0]       WrAddr,
    output logic [WORD_W-1:0] WrData,
    output logic              CpuHold,
    output logic              Done,
    output logic              Err,
    output logic [ADDR_W:0]   WordCnt
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    state_e              r_state;
    state_e              w_state_nxt;
    logic                r_rx_ready;
    logic                r_wr_en;
    logic [31:0]         r_wr_addr;
    logic [WORD_W-1:0]   r_wr_data;
    logic                r_cpu_hold;
    logic                r_done;
    logic                r_err;
    logic [CNT_W-1:0]    r_word_cnt;
    logic [CNT_W-1:0]    r_len;
    logic [ADDR_W-1:0]   r_word_idx;
`ifdef INST_LOADER_CKSUM_EN
    logic [BYTE_W-1:0]   r_cksum;
`endif

    logic                w_xfer;
    logic                w_start_acc;
    logic                w_len_bad;
    logic                w_last_word;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_word_valid;
    logic [WORD_W-1:0]   w_word;

    assign w_xfer      = RxValid && r_rx_ready;
    assign w_len_bad   = (RxData == '0) || (32'(RxData) > DEPTH);
    assign w_cnt_inc   = r_word_cnt + CNT_W'(1);
    assign w_last_word = (w_cnt_inc == r_len);

    inst_word_packer u_packer (
        .i_clk          (Clk),
        .i_rst_n        (Clrn),
        .i_clear        (w_start_acc),
        .i_byte_en      (w_xfer && (r_state == ST_DATA)),
        .i_byte         (RxData),
        .o_word_c       (w_word),
        .o_word_valid_c (w_word_valid)
    );

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = ST_LEN;
                end
            end
            ST_LEN:   if (w_xfer) w_state_nxt = w_len_bad ? ST_IDLE : ST_DATA;
            ST_DATA:  if (w_word_valid) w_state_nxt = ST_WRITE;
            ST_WRITE: begin
`ifdef INST_LOADER_CKSUM_EN
                w_state_nxt = w_last_word ? ST_CHK : ST_DATA;
`else
                w_state_nxt = w_last_word ? ST_DONE : ST_DATA;
`endif
            end
`ifdef INST_LOADER_CKSUM_EN
            ST_CHK:   if (w_xfer) w_state_nxt = ST_DONE;
`endif
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            r_rx_ready <= 1'b0;
            r_wr_en    <= 1'b0;
            r_cpu_hold <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_rx_ready <= (w_state_nxt == ST_LEN) || (w_state_nxt == ST_DATA) ||
                          (w_state_nxt == ST_CHK);
            r_wr_en    <= (w_state_nxt == ST_WRITE);
            r_cpu_hold <= (w_state_nxt == ST_LEN) || (w_state_nxt == ST_DATA) ||
                          (w_state_nxt == ST_WRITE) || (w_state_nxt == ST_CHK);
            r_done     <= (w_state_nxt == ST_DONE);
        end
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            r_err      <= 1'b0;
            r_word_cnt <= '0;
            r_word_idx <= '0;
            r_len      <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
`ifdef INST_LOADER_CKSUM_EN
            r_cksum    <= '0;
`endif
        end else begin
            if (w_start_acc) begin
                r_err      <= 1'b0;
                r_word_cnt <= '0;
                r_word_idx <= '0;
`ifdef INST_LOADER_CKSUM_EN
                r_cksum    <= '0;
`endif
            end
            if ((r_state == ST_LEN) && w_xfer) begin
                if (w_len_bad) r_err <= 1'b1;
                else           r_len <= CNT_W'(RxData);
            end
`ifdef INST_LOADER_CKSUM_EN
            if ((r_state == ST_DATA) && w_xfer) r_cksum <= r_cksum ^ RxData;
            if ((r_state == ST_CHK) && w_xfer && (RxData != r_cksum)) r_err <= 1'b1;
`endif
            if (w_word_valid) begin
                r_wr_data <= w_word;
                r_wr_addr <= 32'({r_word_idx, {INST_ADDR_LSB{1'b0}}});
            end
            if (r_state == ST_WRITE) begin
                r_word_idx <= r_word_idx + ADDR_W'(1);
                r_word_cnt <= w_cnt_inc;
            end
        end
    end

    assign RxReady = r_rx_ready;
    assign WrEn    = r_wr_en;
    assign WrAddr  = r_wr_addr;
    assign WrData  = r_wr_data;
    assign CpuHold = r_cpu_hold;
    assign Done    = r_done;
    assign Err     = r_err;
    assign WordCnt = r_word_cnt;

endmodule

// File: tb/tb_inst_loader.sv
// Randomized self-checking bench for inst_loader against a session-level reference model.
module tb_inst_loader;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef INST_LOADER_CKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic              Clk = 1'b0;
    logic              Clrn;
    logic              Start;
    logic [7:0]        RxData;
    logic              RxValid;
    logic              RxReady;
    logic              WrEn;
    logic [31:0]       WrAddr;
    logic [31:0]       WrData;
    logic              CpuHold;
    logic              Done;
    logic              Err;
    logic [ADDR_W:0]   WordCnt;

    int tests = 0;
    int fails = 0;

    logic [31:0] data_w [0:255];
    logic [63:0] wq [$];
    logic        prev_we = 1'b0;
    int          b2b = 0;

    inst_loader #(.ADDR_W(ADDR_W)) dut (
        .Clk     (Clk),
        .Clrn    (Clrn),
        .Start   (Start),
        .RxData  (RxData),
        .RxValid (RxValid),
        .RxReady (RxReady),
        .WrEn    (WrEn),
        .WrAddr  (WrAddr),
        .WrData  (WrData),
        .CpuHold (CpuHold),
        .Done    (Done),
        .Err     (Err),
        .WordCnt (WordCnt)
    );

    always #5 Clk = ~Clk;

    // Write-port monitor: logs every strobe and counts back-to-back strobes.
    always @(negedge Clk) begin
        if (WrEn) begin
            wq.push_back({WrAddr, WrData});
            if (prev_we) b2b <= b2b + 1;
        end
        prev_we <= WrEn;
    end

    task automatic pulse_start();
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gapmax);
        int t;
        repeat ($urandom_range(0, gapmax)) @(negedge Clk);
        RxData  = b;
        RxValid = 1'b1;
        t = 0;
        while (!RxReady && t < 200) begin
            @(negedge Clk);
            t++;
        end
        if (!RxReady) begin
            tests++; fails++;
            $display("FAIL send_byte: RxReady never rose for byte %02h", b);
        end
        @(posedge Clk);
        #1 RxValid = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        tests++;
        if ({RxReady, WrEn, WrAddr, WrData, CpuHold, Done, Err, WordCnt} !== '0) begin
            fails++;
            $display("FAIL %s: outputs rdy=%b we=%b a=%h d=%h hold=%b done=%b err=%b cnt=%0d, required all zero",
                     name, RxReady, WrEn, WrAddr, WrData, CpuHold, Done, Err, WordCnt);
        end
    endtask

    // One complete session; expectations derive from n, the data table and the checksum rule.
    task automatic do_session(input int n, input int gapmax, input bit bad_ck,
                              input int start_at, input string name);
        int qb, bb, t, nexp;
        bit valid;
        logic [7:0] ck, b;
        logic [63:0] e;
        qb = wq.size();
        bb = b2b;
        ck = 8'h00;
        valid = (n >= 1) && (n <= DEPTH);
        pulse_start();
        @(negedge Clk);
        tests++;
        if (Err !== 1'b0 || CpuHold !== 1'b1) begin
            fails++;
            $display("FAIL %s_start: err=%b hold=%b, required err=0 hold=1", name, Err, CpuHold);
        end
        send_byte(8'(n), gapmax);
        if (valid) begin
            for (int w = 0; w < n; w++) begin
                for (int k = 0; k < 4; k++) begin
                    b = data_w[w][8*(3-k) +: 8];
                    if (w*4 + k == start_at) pulse_start();
                    ck = ck ^ b;
                    send_byte(b, gapmax);
                end
            end
            if (CK_EN) send_byte(ck ^ 8'(bad_ck), gapmax);
        end
        t = 0;
        while (CpuHold && t < 200) begin
            @(negedge Clk);
            t++;
        end
        @(negedge Clk);
        nexp = valid ? n : 0;
        tests++;
        if (CpuHold !== 1'b0) begin
            fails++;
            $display("FAIL %s_hold: CpuHold=%b, required 0", name, CpuHold);
        end
        tests++;
        if (Done !== valid) begin
            fails++;
            $display("FAIL %s_done: Done=%b, required %b", name, Done, valid);
        end
        tests++;
        if (Err !== (!valid || (CK_EN && bad_ck))) begin
            fails++;
            $display("FAIL %s_err: Err=%b, required %b", name, Err, (!valid || (CK_EN && bad_ck)));
        end
        tests++;
        if (WordCnt !== (ADDR_W+1)'(nexp)) begin
            fails++;
            $display("FAIL %s_cnt: WordCnt=%0d, required %0d", name, WordCnt, nexp);
        end
        tests++;
        if (wq.size() - qb !== nexp) begin
            fails++;
            $display("FAIL %s_nwr: writes=%0d, required %0d", name, wq.size() - qb, nexp);
        end
        for (int i = 0; i < nexp && qb + i < wq.size(); i++) begin
            e = {32'(i * 4), data_w[i]};
            tests++;
            if (wq[qb + i] !== e) begin
                fails++;
                $display("FAIL %s_wr%0d: addr/data=%h, required %h", name, i, wq[qb + i], e);
            end
        end
        tests++;
        if (b2b !== bb) begin
            fails++;
            $display("FAIL %s_b2b: back-to-back strobes=%0d, required 0", name, b2b - bb);
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) data_w[i] = $urandom;
    endtask

    task automatic test_reset();
        Clrn = 1'b0; Start = 1'b0; RxValid = 1'b0; RxData = 8'h00;
        repeat (3) @(negedge Clk);
        check_all_zero("reset");
        Clrn = 1'b1;
        @(negedge Clk);
        check_all_zero("post_reset");
    endtask

    task automatic test_basic();
        data_w[0] = 32'h3401000A;
        data_w[1] = 32'h20020006;
        do_session(2, 0, 1'b0, -1, "basic_n2");
        tests++;
        if (WrData !== 32'h20020006) begin
            fails++;
            $display("FAIL basic_hold_data: WrData=%h, required 20020006", WrData);
        end
    endtask

    task automatic test_bad_len();
        do_session(0, 2, 1'b0, -1, "len0");
        do_session(DEPTH + 1, 2, 1'b0, -1, "len_over");
        fill_random(3);
        do_session(3, 2, 1'b0, -1, "len_recover");
    endtask

    task automatic test_gaps_full();
        fill_random(DEPTH);
        do_session(DEPTH, 7, 1'b0, -1, "gaps_full");
    endtask

    task automatic test_random_sessions();
        for (int s = 0; s < 3; s++) begin
            int n;
            n = $urandom_range(1, DEPTH);
            fill_random(n);
            do_session(n, 3, 1'b0, -1, "rand");
        end
    endtask

    task automatic test_mid_start();
        fill_random(4);
        do_session(4, 1, 1'b0, 6, "mid_start");
    endtask

    task automatic test_mid_reset();
        logic [7:0] b;
        fill_random(5);
        pulse_start();
        send_byte(8'd5, 1);
        for (int i = 0; i < 14; i++) begin
            b = data_w[i / 4][8*(3 - i % 4) +: 8];
            send_byte(b, 1);
        end
        @(negedge Clk);
        Clrn = 1'b0;
        #1 check_all_zero("mid_reset");
        @(negedge Clk);
        Clrn = 1'b1;
        fill_random(2);
        do_session(2, 1, 1'b0, -1, "after_reset");
    endtask

    task automatic test_cksum();
        data_w[0] = 32'h0000000C;
        do_session(1, 0, 1'b0, -1, "cksum_good");
        do_session(1, 0, 1'b1, -1, "cksum_bad");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_len();
        test_gaps_full();
        test_random_sessions();
        test_mid_start();
        test_mid_reset();
        if (CK_EN) test_cksum();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
